// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, sequencer states and multi-cycle mode select for alu_seq.
// Holds no logic, so it adds no latency and exerts no backpressure.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  typedef enum logic {MD_MUL, MD_DIV} md_mode_t;

endpackage

// File: rtl/alu_seq_muldiv_core.sv
// Radix-2 Booth multiplier / restoring divider with sign fix-up on the result taps.
// One step per load/step edge (WIDTH steps total); no backpressure, the caller paces it.
module alu_seq_muldiv_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             fin,
  input  md_mode_t         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             dz
);

  localparam int SHW = $clog2(WIDTH);

  md_mode_t         mode_q, src_mode;
  logic [WIDTH:0]   hi_q, src_hi, nxt_hi, sum, rem_sh;
  logic [WIDTH-1:0] lo_q, src_lo, nxt_lo, m_q, src_m, abs_a, abs_b;
  logic             qm1_q, src_qm1, nxt_qm1, sa_q, sb_q;
  logic [SHW-1:0]   cnt_q;

  // The load edge already performs the first step so the whole op fits in WIDTH+1 edges.
  always_comb begin
    abs_a = a[WIDTH-1] ? -a : a;
    abs_b = b[WIDTH-1] ? -b : b;
    if (load) begin
      src_mode = mode;
      src_hi   = '0;
      src_qm1  = 1'b0;
      src_lo   = (mode == MD_DIV) ? abs_a : b;
      src_m    = (mode == MD_DIV) ? abs_b : a;
    end else begin
      src_mode = mode_q;
      src_hi   = hi_q;
      src_lo   = lo_q;
      src_m    = m_q;
      src_qm1  = qm1_q;
    end
  end

  always_comb begin
    sum     = src_hi;
    rem_sh  = {src_hi[WIDTH-1:0], src_lo[WIDTH-1]};
    nxt_hi  = src_hi;
    nxt_lo  = src_lo;
    nxt_qm1 = 1'b0;
    if (src_mode == MD_MUL) begin
      case ({src_lo[0], src_qm1})
        2'b01:   sum = src_hi + {src_m[WIDTH-1], src_m};
        2'b10:   sum = src_hi - {src_m[WIDTH-1], src_m};
        default: sum = src_hi;
      endcase
      nxt_hi  = {sum[WIDTH], sum[WIDTH:1]};
      nxt_lo  = {sum[0], src_lo[WIDTH-1:1]};
      nxt_qm1 = src_lo[0];
    end else if (rem_sh >= {1'b0, src_m}) begin
      nxt_hi = rem_sh - {1'b0, src_m};
      nxt_lo = {src_lo[WIDTH-2:0], 1'b1};
    end else begin
      nxt_hi = rem_sh;
      nxt_lo = {src_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= MD_MUL;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
      qm1_q  <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      mode_q <= src_mode;
      hi_q   <= nxt_hi;
      lo_q   <= nxt_lo;
      qm1_q  <= nxt_qm1;
      m_q    <= src_m;
      sa_q   <= a[WIDTH-1];
      sb_q   <= b[WIDTH-1];
      cnt_q  <= '0;
    end else if (step) begin
      hi_q   <= nxt_hi;
      lo_q   <= nxt_lo;
      qm1_q  <= nxt_qm1;
      cnt_q  <= cnt_q + SHW'(1);
    end else if (fin) begin
      cnt_q  <= '0;
    end
  end

  // A zero divisor accepts every trial subtract: quotient saturates to all ones and the
  // remainder path rebuilds |A|, which the dividend-sign fix-up turns back into A.
  always_comb begin
    last = (cnt_q == SHW'(WIDTH - 2));
    dz   = (mode_q == MD_DIV) && (m_q == '0);
    if (mode_q == MD_MUL) begin
      res_hi = hi_q[WIDTH-1:0];
      res_lo = lo_q;
    end else begin
      res_hi = sa_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
      res_lo = dz ? '1 : ((sa_q ^ sb_q) ? -lo_q : lo_q);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle R-format ops plus multi-cycle signed mul/div into HI/LO.
// Latency 1 (single ops) or WIDTH+1 (mul/div); start is ignored while busy, nothing queues.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             IncPC,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C_out_HI,
  output logic [WIDTH-1:0] C_out_LO,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] rot_tmp;
  logic [WIDTH-1:0]   sc_res, md_hi, md_lo;
  logic               sc_legal, is_muldiv, md_load, md_last, md_dz;
  md_mode_t           md_mode;

  always_comb begin
    shamt     = B[SHW-1:0];
    rot_tmp   = '0;
    sc_res    = '0;
    sc_legal  = 1'b1;
    is_muldiv = 1'b0;
    md_mode   = MD_MUL;
    case (opcode)
      OP_ADD:  sc_res = A + B;
      OP_SUB:  sc_res = A - B;
      OP_SHR:  sc_res = A >> shamt;
      OP_SHRA: sc_res = $signed(A) >>> shamt;
      OP_SHL:  sc_res = A << shamt;
      OP_ROR: begin
        rot_tmp = {A, A} >> shamt;
        sc_res  = rot_tmp[WIDTH-1:0];
      end
      OP_ROL: begin
        rot_tmp = {A, A} << shamt;
        sc_res  = rot_tmp[2*WIDTH-1:WIDTH];
      end
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_NEG:  sc_res = -A;
      OP_NOT:  sc_res = ~A;
      OP_MUL:  is_muldiv = 1'b1;
      OP_DIV: begin
        is_muldiv = 1'b1;
        md_mode   = MD_DIV;
      end
      default: sc_legal = 1'b0;
    endcase
  end

  assign md_load = (state == IDLE) && start && !IncPC && is_muldiv;

  alu_seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .load   (md_load),
    .step   (state == ITER),
    .fin    (state == FIN),
    .mode   (md_mode),
    .a      (A),
    .b      (B),
    .last   (md_last),
    .res_hi (md_hi),
    .res_lo (md_lo),
    .dz     (md_dz)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      C_out_HI    <= '0;
      C_out_LO    <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (IncPC) begin
              C_out_HI    <= '0;
              C_out_LO    <= A + WIDTH'(1);
              div_by_zero <= 1'b0;
              illegal_op  <= 1'b0;
              done        <= 1'b1;
            end else if (is_muldiv) begin
              busy  <= 1'b1;
              state <= ITER;
            end else begin
              C_out_HI    <= '0;
              C_out_LO    <= sc_legal ? sc_res : '0;
              div_by_zero <= 1'b0;
              illegal_op  <= !sc_legal;
              done        <= 1'b1;
            end
          end
        end
        ITER: if (md_last) state <= FIN;
        FIN: begin
          C_out_HI    <= md_hi;
          C_out_LO    <= md_lo;
          div_by_zero <= md_dz;
          illegal_op  <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hand-built multi-cycle
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;

  logic        clock = 1'b0;
  logic        reset, start, IncPC;
  logic [4:0]  opcode;
  logic [31:0] A, B, c_hi, c_lo;
  logic        busy, done, div_by_zero, illegal_op;

  logic        start8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, dz8, ill8;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  op;
    logic        inc;
    logic [31:0] a, b, hi, lo;
    logic        dz, ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  alu_seq #(.WIDTH(32)) u_dut (
    .clock(clock), .reset(reset), .start(start), .IncPC(IncPC), .opcode(opcode),
    .A(A), .B(B), .busy(busy), .done(done), .C_out_HI(c_hi), .C_out_LO(c_lo),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .start(start8), .IncPC(1'b0), .opcode(op8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .C_out_HI(hi8), .C_out_LO(lo8),
    .div_by_zero(dz8), .illegal_op(ill8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] op, input logic inc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input logic dz, input logic ill, input int lat);
    vec_t v;
    v.op = op; v.inc = inc; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
    v.dz = dz; v.ill = ill; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issues one op and waits (bounded) for done; lat=0 means no done arrived.
  task automatic run_op(input logic [4:0] op, input logic inc, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output int busy_cyc);
    @(negedge clock);
    opcode = op; IncPC = inc; A = a; B = b; start = 1'b1;
    lat = 0;
    busy_cyc = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  // Reference model straight from the arithmetic rules, using 64-bit signed math.
  task automatic model(input logic [4:0] op, input logic inc, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] hi, output logic [31:0] lo,
                       output logic dz, output logic ill, output int lat);
    longint sa, sb, p, q, r;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    hi = 0; lo = 0; dz = 0; ill = 0; lat = 1;
    if (inc) lo = a + 32'd1;
    else case (op)
      5'b00011: lo = a + b;
      5'b00100: lo = a - b;
      5'b00101: lo = a >> sh;
      5'b00110: lo = $signed(a) >>> sh;
      5'b00111: lo = a << sh;
      5'b01000: begin lo = a; repeat (sh) lo = {lo[0], lo[31:1]}; end
      5'b01001: begin lo = a; repeat (sh) lo = {lo[30:0], lo[31]}; end
      5'b01010: lo = a & b;
      5'b01011: lo = a | b;
      5'b10001: lo = 32'd0 - a;
      5'b10010: lo = ~a;
      5'b01111: begin
        p = sa * sb;
        hi = p[63:32]; lo = p[31:0]; lat = 33;
      end
      5'b10000: begin
        lat = 33;
        if (b == 0) begin
          dz = 1; lo = 32'hFFFFFFFF; hi = a;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
      default: ill = 1;
    endcase
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcyc, ndone, first;
    logic [31:0] ehi, elo, saved_lo;
    logic edz, eill;
    logic [4:0] legal_ops[13];

    legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                  5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010};

    add_vec(5'b00011, 0, 5, 7, 0, 32'h0000000C, 0, 0, 1);
    add_vec(5'b01000, 0, 32'h80000001, 1, 0, 32'hC0000000, 0, 0, 1);
    add_vec(5'b01111, 0, 32'hFFFFFFFD, 7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0, 33);
    add_vec(5'b10000, 0, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 33);
    add_vec(5'b10000, 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 0, 33);
    add_vec(5'b10000, 0, 25, 0, 25, 32'hFFFFFFFF, 1, 0, 33);
    add_vec(5'b00011, 0, 1, 2, 0, 3, 0, 0, 1);
    add_vec(5'b11111, 0, 32'h1234, 5, 0, 0, 0, 1, 1);
    add_vec(5'b11111, 1, 32'h100, 0, 0, 32'h101, 0, 0, 1);
    add_vec(5'b00110, 0, 32'h80000000, 32'h24, 0, 32'hF8000000, 0, 0, 1);
    add_vec(5'b00111, 0, 32'h1234, 32'h20, 0, 32'h1234, 0, 0, 1);
    add_vec(5'b01001, 0, 32'h80000001, 33, 0, 32'h00000003, 0, 0, 1);
    add_vec(5'b00100, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 1);
    add_vec(5'b10001, 0, 1, 99, 0, 32'hFFFFFFFF, 0, 0, 1);
    add_vec(5'b10010, 0, 32'h0F0F0F0F, 0, 0, 32'hF0F0F0F0, 0, 0, 1);
    add_vec(5'b00101, 0, 32'hF0000000, 4, 0, 32'h0F000000, 0, 0, 1);
    add_vec(5'b01010, 0, 32'hFF00FF00, 32'h0FF00FF0, 0, 32'h0F000F00, 0, 0, 1);
    add_vec(5'b01011, 0, 32'hFF00FF00, 32'h0FF00FF0, 0, 32'hFFF0FFF0, 0, 0, 1);
    add_vec(5'b10000, 0, 7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 0, 0, 33);
    add_vec(5'b01111, 0, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0, 0, 33);

    reset = 1; start = 0; IncPC = 0; opcode = 0; A = 0; B = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", c_hi, 0);
    check("reset_lo", c_lo, 0);
    check("reset_flags", {div_by_zero, illegal_op}, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].inc, vecs[i].a, vecs[i].b, lat, bcyc);
      check($sformatf("vec%0d_lo", i), c_lo, vecs[i].lo);
      check($sformatf("vec%0d_hi", i), c_hi, vecs[i].hi);
      check($sformatf("vec%0d_dz", i), div_by_zero, vecs[i].dz);
      check($sformatf("vec%0d_ill", i), illegal_op, vecs[i].ill);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy", i), bcyc, vecs[i].lat - 1);
    end

    // Back-to-back single-cycle starts produce a done on every edge.
    @(negedge clock);
    opcode = 5'b00011; IncPC = 0; A = 1; B = 1; start = 1;
    @(posedge clock); #1;
    check("b2b_done1", done, 1);
    check("b2b_lo1", c_lo, 2);
    opcode = 5'b00100; A = 5; B = 3;
    @(posedge clock); #1;
    check("b2b_done2", done, 1);
    check("b2b_lo2", c_lo, 2);
    start = 0;
    @(posedge clock); #1;
    check("b2b_done_drop", done, 0);

    // Start re-pulsed while a multiply is busy must be ignored.
    @(negedge clock);
    opcode = 5'b01111; A = 32'hFFFFFFFD; B = 7; start = 1;
    ndone = 0; first = 0; saved_lo = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = n;
          saved_lo = c_lo;
        end
      end
      if (n == 9) begin
        start = 1; opcode = 5'b00011; A = 1; B = 1;
      end else start = 0;
    end
    check("busy_ign_count", ndone, 1);
    check("busy_ign_edge", first, 33);
    check("busy_ign_lo", saved_lo, 32'hFFFFFFEB);

    // Reset in the middle of a multiply aborts it with no late done.
    @(negedge clock);
    opcode = 5'b01111; A = 32'hFFFFFFFD; B = 7; start = 1;
    ndone = 0;
    for (int n = 1; n <= 55; n++) begin
      @(posedge clock); #1;
      start = 0;
      if (n == 14) reset = 1;
      if (n == 15) begin
        reset = 0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hi", c_hi, 0);
        check("mid_rst_lo", c_lo, 0);
        check("mid_rst_done", done, 0);
      end
      if (n > 15 && done) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);

    // Reset and start on the same edge: reset wins.
    @(negedge clock);
    opcode = 5'b00011; A = 3; B = 4; start = 1; reset = 1;
    @(posedge clock); #1;
    start = 0; reset = 0;
    check("rst_vs_start_done", done, 0);
    check("rst_vs_start_lo", c_lo, 0);

    // Narrow build: 0x7F * 0x7F.
    @(negedge clock);
    op8 = 5'b01111; a8 = 8'h7F; b8 = 8'h7F; start8 = 1;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock); #1;
      start8 = 0;
      if (done8) begin
        lat = n;
        break;
      end
    end
    check("w8_lat", lat, 9);
    check("w8_hi", hi8, 8'h3F);
    check("w8_lo", lo8, 8'h01);

    for (int i = 0; i < 150; i++) begin
      logic [4:0]  rop;
      logic        rinc;
      logic [31:0] ra, rb;
      rop  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                         : legal_ops[$urandom_range(0, 12)];
      rinc = ($urandom_range(0, 9) == 0);
      ra   = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 0;
        1:       rb = $urandom_range(0, 40);
        2:       rb = -$urandom_range(1, 40);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      model(rop, rinc, ra, rb, ehi, elo, edz, eill, lat);
      run_op(rop, rinc, ra, rb, first, bcyc);
      check($sformatf("rnd%0d_op%0h_lo", i, rop), c_lo, elo);
      check($sformatf("rnd%0d_op%0h_hi", i, rop), c_hi, ehi);
      check($sformatf("rnd%0d_op%0h_dz", i, rop), div_by_zero, edz);
      check($sformatf("rnd%0d_op%0h_ill", i, rop), illegal_op, eill);
      check($sformatf("rnd%0d_op%0h_lat", i, rop), first, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
